// File: rtl/dram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between four cores.
// One access at a time; read data and a one-cycle ack go to the winning lane.
module dram_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_rd,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [DW-1:0]     ram_q,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_wren,
    output logic [NREQ-1:0]   acq,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ*DW-1:0] rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam logic [NREQ-1:0] ONE = 1;

    state_t              state_q;
    logic [1:0]          ptr_q;
    logic [1:0]          w_q;
    logic [1:0]          cnt_q;
    logic                wr_q;
    logic [NREQ-1:0]     acq_q;
    logic [NREQ-1:0]     ack_q;
    logic [AW-1:0]       ram_addr_q;
    logic [DW-1:0]       ram_din_q;
    logic                ram_wren_q;
    logic [NREQ*DW-1:0]  rdata_q;

    logic [NREQ-1:0]     pend;
    logic [1:0]          win_d;
    logic [1:0]          idx;
    logic                found;

    assign pend = req_rd | req_wr;

    // First pending lane scanning upward from ptr, wrapping mod 4
    always_comb begin
        win_d = ptr_q;
        found = 1'b0;
        idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend[idx]) begin
                win_d = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            w_q        <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            acq_q      <= '0;
            ack_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_wren_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        w_q        <= win_d;
                        acq_q      <= ONE << win_d;
                        ram_addr_q <= addr[win_d*AW +: AW];
                        ram_din_q  <= wdata[win_d*DW +: DW];
                        ram_wren_q <= req_wr[win_d];
                        wr_q       <= req_wr[win_d];
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_wren_q <= 1'b0;
                    if (wr_q) begin
                        ack_q   <= acq_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= 2'(RD_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        rdata_q[w_q*DW +: DW] <= ram_q;
                        ack_q   <= acq_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ACK: begin
                    ptr_q   <= w_q + 2'd1;
                    acq_q   <= '0;
                    ack_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_wren = ram_wren_q;
    assign acq      = acq_q;
    assign ack      = ack_q;
    assign rdata    = rdata_q;
    assign busy     = (state_q != IDLE) | (|pend);

endmodule

// File: tb/tb_dram_rr_arbiter.sv
// Directed bench for dram_rr_arbiter with a behavioural RD_LAT=1 RAM.
// Expected values are hand-derived from the arbitration rules.
module tb_dram_rr_arbiter;

    logic        CLK = 1'b0;
    logic        rst;
    logic [3:0]  req_rd, req_wr;
    logic [31:0] addr, wdata;
    logic [7:0]  ram_q;
    logic [7:0]  ram_addr, ram_din;
    logic        ram_wren;
    logic [3:0]  acq, ack;
    logic [31:0] rdata;
    logic        busy;

    logic [7:0]  mem [256];
    logic        pl_we;
    logic [7:0]  pl_a, pl_d;

    int n_vec = 0;
    int n_err = 0;

    dram_rr_arbiter #(.NREQ(4), .AW(8), .DW(8), .RD_LAT(1)) dut (
        .CLK(CLK), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .ram_q(ram_q),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_wren(ram_wren),
        .acq(acq), .ack(ack), .rdata(rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pl_we) mem[pl_a] <= pl_d;
        else if (ram_wren) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_ack(output logic [3:0] a, output int cyc);
        a = 4'h0;
        cyc = 0;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (ack != 4'h0) begin
                a = ack;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] a;
        logic [3:0] prev;
        logic [3:0] order [5];
        int cyc, viol, n, txn;

        rst = 1'b0; pl_we = 1'b0; pl_a = 8'h0; pl_d = 8'h0;
        req_rd = 4'($urandom); req_wr = 4'($urandom);
        addr = $urandom; wdata = $urandom;
        repeat (3) tick();
        check("rst_acq", 32'(acq), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_wren", 32'(ram_wren), 32'h0);
        check("rst_addr", 32'(ram_addr), 32'h0);
        check("rst_din", 32'(ram_din), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'(|(req_rd | req_wr)));

        for (int i = 0; i < 4; i++) begin
            pl_we = 1'b1; pl_a = 8'h20 + 8'(i); pl_d = 8'hC0 + 8'(i);
            tick();
        end
        pl_we = 1'b0;
        req_rd = 4'h0; req_wr = 4'h0; addr = '0; wdata = '0;
        tick();
        rst = 1'b1;
        viol = 0;
        repeat (10) begin
            tick();
            if (acq != 4'h0 || busy != 1'b0) viol++;
        end
        check("idle_quiet", 32'(viol), 32'h0);

        // single write, core2
        addr[16 +: 8] = 8'h10; wdata[16 +: 8] = 8'hA5; req_wr = 4'b0100;
        tick();
        check("wr_iss_addr", 32'(ram_addr), 32'h10);
        check("wr_iss_din", 32'(ram_din), 32'hA5);
        check("wr_iss_wren", 32'(ram_wren), 32'h1);
        check("wr_iss_acq", 32'(acq), 32'h4);
        check("wr_iss_ack", 32'(ack), 32'h0);
        tick();
        check("wr_c2_wren", 32'(ram_wren), 32'h0);
        check("wr_c2_ack", 32'(ack), 32'h4);
        check("wr_c2_acq", 32'(acq), 32'h4);
        req_wr = 4'h0;
        tick();
        check("wr_c3_ack", 32'(ack), 32'h0);
        check("wr_c3_acq", 32'(acq), 32'h0);
        check("wr_mem", 32'(mem[8'h10]), 32'hA5);

        // read back on core1
        addr[8 +: 8] = 8'h10; req_rd = 4'b0010;
        tick();
        check("rd_iss_acq", 32'(acq), 32'h2);
        check("rd_iss_wren", 32'(ram_wren), 32'h0);
        check("rd_iss_addr", 32'(ram_addr), 32'h10);
        tick();
        check("rd_c2_ack", 32'(ack), 32'h0);
        tick();
        check("rd_c3_ack", 32'(ack), 32'h2);
        check("rd_c3_rdata", rdata, 32'h0000A500);
        req_rd = 4'h0;
        tick();

        // contention from reset, ptr=0
        rst = 1'b0;
        addr = 32'h23222120;
        req_rd = 4'hF;
        tick();
        rst = 1'b1;
        viol = 0; n = 0; prev = 4'h0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            if ($countones(acq) > 1) viol++;
            if ($countones(ack) > 1) viol++;
            if ((ack & prev) != 4'h0) viol++;
            if (ack != 4'h0) begin
                order[n] = ack;
                n++;
            end
            prev = ack;
        end
        req_rd = 4'h0;
        check("cont_count", 32'(n), 32'd5);
        check("cont_g0", 32'(order[0]), 32'h1);
        check("cont_g1", 32'(order[1]), 32'h2);
        check("cont_g2", 32'(order[2]), 32'h4);
        check("cont_g3", 32'(order[3]), 32'h8);
        check("cont_g4", 32'(order[4]), 32'h1);
        check("cont_onehot", 32'(viol), 32'h0);
        check("cont_rdata", rdata, 32'hC3C2C1C0);
        tick();

        // fairness: core0 continuous, core3 once
        req_rd = 4'b0001;
        wait_ack(a, cyc);
        check("fair_c0", 32'(a), 32'h1);
        req_rd = 4'b1001;
        txn = 0;
        a = 4'h0;
        while (txn < 4 && a != 4'h8) begin
            wait_ack(a, cyc);
            txn++;
        end
        check("fair_c3", 32'(a), 32'h8);
        check("fair_txn", 32'(txn), 32'd1);
        req_rd = 4'b0001;
        wait_ack(a, cyc);
        check("fair_c0_again", 32'(a), 32'h1);
        req_rd = 4'h0;
        tick();

        // core1 write leaves ptr=2
        addr[8 +: 8] = 8'h40; wdata[8 +: 8] = 8'h77; req_wr = 4'b0010;
        wait_ack(a, cyc);
        check("w1_ack", 32'(a), 32'h2);
        req_wr = 4'h0;
        tick();

        // reset during the WAIT of a core2 read
        addr[16 +: 8] = 8'h20; req_rd = 4'b0100;
        tick();
        tick();
        rst = 1'b0;
        req_rd = 4'h0;
        #1;
        check("mid_acq", 32'(acq), 32'h0);
        check("mid_wren", 32'(ram_wren), 32'h0);
        check("mid_ack", 32'(ack), 32'h0);
        viol = 0;
        repeat (3) begin
            tick();
            if (ack != 4'h0) viol++;
        end
        check("mid_no_ack", 32'(viol), 32'h0);
        rst = 1'b1;
        addr[8 +: 8] = 8'h21; addr[24 +: 8] = 8'h23;
        req_rd = 4'b1010;
        wait_ack(a, cyc);
        check("post_first", 32'(a), 32'h2);
        check("post_lat", 32'(cyc), 32'd3);
        req_rd = 4'b1000;
        wait_ack(a, cyc);
        check("post_c3", 32'(a), 32'h8);
        check("post_rdata", rdata, 32'hC300C100);
        req_rd = 4'h0;
        tick();

        // read+write together is a write
        addr[0 +: 8] = 8'h30; wdata[0 +: 8] = 8'h5A;
        req_rd = 4'b0001; req_wr = 4'b0001;
        wait_ack(a, cyc);
        check("rw_ack", 32'(a), 32'h1);
        check("rw_lat", 32'(cyc), 32'd2);
        req_rd = 4'h0; req_wr = 4'h0;
        tick();
        check("rw_mem", 32'(mem[8'h30]), 32'h5A);
        check("rw_rdata", rdata, 32'hC300C100);
        check("end_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dram_rr_arbiter.md
Name: dram_rr_arbiter

Overview:
- Round-robin arbiter that shares the single-port 8-bit data RAM between four cores.
- Each core issues read/write requests on its own 8-bit lane.
- The block serialises them into one RAM access at a time and drives the RAM address, data and write-enable.
- It waits out the RAM read latency, returns read data on the winner's lane and pulses a per-core ack; it sits between the cores' data-memory ports and the DRAM instance.

Parameters:
NREQ, 4, number of requesters; fixed at 4, lanes packed {3,2,1,0}.
AW, 8, RAM address width.
DW, 8, RAM data width.
RD_LAT, 1, clock edges from RAM sampling address to ram_q valid; legal 1..3.

Ports:
CLK  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
req_rd  in  4  per-core read request, level.
req_wr  in  4  per-core write request, level.
addr  in  4*AW  per-core address, lane i = bits [i*AW +: AW].
wdata  in  4*DW  per-core write data, lane i.
ram_q  in  DW  RAM read data.
ram_addr  out  AW  registered RAM address.
ram_din  out  DW  registered RAM write data.
ram_wren  out  1  registered RAM write enable.
acq  out  4  one-hot grant; 0 when idle.
ack  out  4  one-cycle completion pulse, one-hot.
rdata  out  4*DW  per-core read data, lane i held until next read by core i.
busy  out  1  high when state != IDLE or any request pending.

Behaviour:
- Reset (rst=0, async): state=IDLE, acq=0, ack=0, ram_wren=0, ram_addr=0, ram_din=0, rdata=0, ptr=0. Effect is immediate, mid-transaction included; an in-flight read is discarded and no ack is issued.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - pend[i] = req_rd[i] | req_wr[i].
  - If pend != 0, the winner w is the first set bit scanning ptr, ptr+1, … mod 4.
  - Register acq=onehot(w), ram_addr=addr[w], ram_din=wdata[w], ram_wren=req_wr[w]; go to ISSUE.
  - If req_rd[w] and req_wr[w] are both high, the access is a write; the read is not performed.
- ISSUE (1 cycle): RAM samples address/data/wren at the ending edge.
  - Next state is ACK for a write, WAIT with cnt=RD_LAT-1 for a read.
  - ram_wren is cleared at this edge, so a write is exactly one cycle wide.
- WAIT: if cnt==0, capture ram_q into rdata lane w and go to ACK; else cnt-=1.
- ACK (1 cycle): ack[w]=1, acq still = onehot(w).
  - At the ending edge: ptr=(w+1) mod 4, acq=0, ack=0, go to IDLE.
- Latency, request seen in IDLE cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT, rdata valid in the same cycle as ack.
- Requester rules:
  - Hold req and addr/wdata stable until ack is seen; drop req the cycle after ack.
  - Requests are sampled only in IDLE; changes during ISSUE/WAIT/ACK are ignored.
  - A request dropped before ack still completes and is still acked.
- Fairness: the granted core becomes lowest priority. A continuously requesting core waits at most 3 other transactions.
- Back-to-back: at least one IDLE cycle separates transactions.
- Only lane w of rdata changes per read; other lanes hold.
- ram_addr/ram_din hold their last value when idle.
- busy is combinational from state and req inputs.

Test Plan:
- Reset: drive random req with rst=0 -> all outputs 0, state IDLE. Release rst, no req -> acq=0, busy=0 for 10 cycles.
- Single write: core2 req_wr, addr=8'h10, wdata=8'hA5 -> ISSUE cycle shows ram_addr=10, ram_din=A5, ram_wren=1 for exactly 1 cycle; ack=4'b0100 in cycle 2; RAM[10]=A5.
- Single read after write (RD_LAT=1): core1 req_rd addr=8'h10 -> ack=4'b0010 in cycle 3, rdata lane1=A5, lanes 0/2/3 unchanged.
- Contention: all four req_rd held from reset (ptr=0) -> grant order 0,1,2,3, then core0 again. acq one-hot and never two bits set; each ack exactly one cycle.
- Fairness: core0 requests continuously, core3 raises req once -> core3 acked within 4 transactions.
- Mid-op reset: assert rst during WAIT of a read -> no ack pulse; ram_wren=0 and acq=0 immediately. After release, a new core3 request is serviced normally with ptr=0 ordering.
